// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage data-memory access unit.
//
// Takes one load/store per instruction, issues it on a registered req/ack
// bus with byte enables and lane-aligned write data, and extends the load
// result. The pipeline is held with m_stall until the access finishes.
// A bus timeout aborts an access that never sees bus_ack.
//
// Build option: define MISALIGN_SPLIT_EN to split word-crossing misaligned
// accesses into two bus transactions. Without it, misaligned half/word
// accesses complete with an address exception and no bus traffic.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   m_valid/m_wr/m_size/m_sext/m_addr/m_wdata   request from MEM stage
//   m_stall           combinational pipeline freeze
//   m_done            one-cycle completion pulse
//   m_rdata, m_exc    load result / exception code, updated on completion
//   bus_req/bus_we/bus_addr/bus_byteen/bus_wdata   registered bus request
//   bus_ack, bus_rdata                             bus completion
module mem_access_unit #(
  parameter int          ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_wr,
  input  logic [1:0]        m_size,
  input  logic              m_sext,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_wdata,
  output logic              m_stall,
  output logic              m_done,
  output logic [31:0]       m_rdata,
  output logic [1:0]        m_exc,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_byteen,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC1 = 2'd1;
  localparam logic [1:0] ACC2 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [1:0]        off_q, size_q;
  logic              sext_q, wr_q;
  logic [3:0]        hi_be_q;
  logic [31:0]       hi_wd_q, first_q;

  // request decode from the live MEM-stage inputs
  logic [1:0]        off;
  logic [3:0]        base;
  logic [31:0]       size_mask;
  logic [7:0]        mask;
  logic [63:0]       wwide;
  logic              misal;
  logic [ADDR_W-1:0] waddr;

  always_comb begin
    off = m_addr[1:0];
    case (m_size)
      2'b00:   begin base = 4'b0001; size_mask = 32'h0000_00ff; end
      2'b01:   begin base = 4'b0011; size_mask = 32'h0000_ffff; end
      default: begin base = 4'b1111; size_mask = 32'hffff_ffff; end
    endcase
    mask  = {4'b0000, base} << off;
    // low word feeds the first access, high word the second; lanes
    // outside the access stay zero because the data is masked first
    wwide = {32'h0, m_wdata & size_mask} << {off, 3'b000};
    misal = (m_size == 2'b01 && m_addr[0]) || (m_size[1] && off != 2'b00);
    waddr = {m_addr[ADDR_W-1:2], 2'b00};
  end

  // load assembly: first word sits low, second (if any) high
  logic [31:0] lo, hi, ext;
  logic [63:0] sh64;

  always_comb begin
    lo   = (state == ACC2) ? first_q : bus_rdata;
    hi   = (state == ACC2) ? bus_rdata : 32'h0;
    sh64 = {hi, lo} >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ext = {{24{sext_q & sh64[7]}},  sh64[7:0]};
      2'b01:   ext = {{16{sext_q & sh64[15]}}, sh64[15:0]};
      default: ext = sh64[31:0];
    endcase
  end

  // abort on the TIMEOUT-th consecutive cycle of waiting without ack
  logic tmo_hit;
  assign tmo_hit = (TIMEOUT != 0) && (32'(cnt) == TIMEOUT - 1);

  assign m_stall = reset & ((state == IDLE & m_valid) | state == ACC1 | state == ACC2);
  assign m_done  = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      wr_q       <= 1'b0;
      hi_be_q    <= '0;
      hi_wd_q    <= '0;
      first_q    <= '0;
      m_rdata    <= '0;
      m_exc      <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_byteen <= '0;
      bus_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_valid) begin
            if (!SPLIT && misal) begin
              m_exc   <= m_wr ? 2'b10 : 2'b01;
              m_rdata <= '0;
              state   <= DONE;
            end else begin
              bus_req    <= 1'b1;
              bus_we     <= m_wr;
              bus_addr   <= waddr;
              bus_byteen <= mask[3:0];
              bus_wdata  <= wwide[31:0];
              hi_be_q    <= mask[7:4];
              hi_wd_q    <= wwide[63:32];
              off_q      <= off;
              size_q     <= m_size;
              sext_q     <= m_sext;
              wr_q       <= m_wr;
              cnt        <= '0;
              state      <= ACC1;
            end
          end
        end
        ACC1, ACC2: begin
          if (bus_ack) begin
            if (state == ACC1 && SPLIT && hi_be_q != 4'b0000) begin
              // second half of a word-crossing access; req stays high
              first_q    <= bus_rdata;
              bus_addr   <= bus_addr + ADDR_W'(4);
              bus_byteen <= hi_be_q;
              bus_wdata  <= hi_wd_q;
              cnt        <= '0;
              state      <= ACC2;
            end else begin
              bus_req <= 1'b0;
              m_exc   <= 2'b00;
              m_rdata <= wr_q ? 32'h0 : ext;
              state   <= DONE;
            end
          end else if (tmo_hit) begin
            // a store whose first half already landed is left as is
            bus_req <= 1'b0;
            m_exc   <= 2'b11;
            m_rdata <= '0;
            state   <= DONE;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;  // DONE: the pipeline advances this cycle
      endcase
    end
  end

endmodule
